// File: rtl/stream_packet_parser.sv
// Serial LSB-first packet deframer: hunts an unaligned sync word, then decodes command, length and payload.
// Define PKT_CRC_EN to append and check a CRC-8 over the command, length and payload bits.
`timescale 1ns/1ps
module stream_packet_parser #(
    parameter int                      HEADER_WIDTH  = 16,
    parameter logic [HEADER_WIDTH-1:0] HEADER        = 16'hBACD,
    parameter int                      COMMAND_WIDTH = 16,
    parameter int                      LENGTH_WIDTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     input_bit,
    input  logic                     is_new_input_bit,
    output logic                     output_bit,
    output logic                     is_new_output_bit,
    output logic [COMMAND_WIDTH-1:0] command,
    output logic                     command_valid,
    output logic [LENGTH_WIDTH-1:0]  payload_length,
    output logic                     packet_done,
    output logic                     busy,
    output logic                     crc_error
);
    localparam int     MAX_A   = (HEADER_WIDTH > COMMAND_WIDTH) ? HEADER_WIDTH : COMMAND_WIDTH;
    localparam int     MAX_B   = (MAX_A > LENGTH_WIDTH) ? MAX_A : LENGTH_WIDTH;
    localparam longint LEN_MAX = (longint'(1) << LENGTH_WIDTH) - 1;
    localparam longint CNT_MAX = (longint'(MAX_B) > LEN_MAX) ? longint'(MAX_B) : LEN_MAX;
    localparam int     CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

`ifdef PKT_CRC_EN
    typedef enum logic [2:0] {HUNT, COMMAND, LENGTH, PAYLOAD, CRC} state_t;
    localparam state_t AFTER_DATA     = CRC;
    localparam logic   DONE_AFTER_DATA = 1'b0;
`else
    typedef enum logic [1:0] {HUNT, COMMAND, LENGTH, PAYLOAD} state_t;
    localparam state_t AFTER_DATA     = HUNT;
    localparam logic   DONE_AFTER_DATA = 1'b1;
`endif

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [HEADER_WIDTH-1:0]   window_q, window_d, window_shift;
    logic [COMMAND_WIDTH-1:0]  cmd_sh_q, cmd_sh_d, cmd_word, command_q, command_d;
    logic [LENGTH_WIDTH-1:0]   len_sh_q, len_sh_d, len_word, length_q, length_d;
    logic                      obit_q, obit_d, ovld_q, ovld_d;
    logic                      cvld_q, cvld_d, done_q, done_d;
    logic                      hdr_match;

    assign window_shift = {input_bit, window_q[HEADER_WIDTH-1:1]};
    assign cmd_word     = {input_bit, cmd_sh_q[COMMAND_WIDTH-1:1]};
    assign len_word     = {input_bit, len_sh_q[LENGTH_WIDTH-1:1]};
    // In HUNT the counter tracks window fill, so a match needs a full window of fresh bits.
    assign hdr_match = is_new_input_bit && (state_q == HUNT) && (window_shift == HEADER) &&
                       (cnt_q >= CNT_W'(HEADER_WIDTH - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        window_d  = window_q;
        cmd_sh_d  = cmd_sh_q;
        len_sh_d  = len_sh_q;
        command_d = command_q;
        length_d  = length_q;
        obit_d    = obit_q;
        ovld_d    = 1'b0;
        cvld_d    = 1'b0;
        done_d    = 1'b0;
        if (is_new_input_bit) begin
            case (state_q)
                HUNT: begin
                    window_d = window_shift;
                    if (hdr_match) begin
                        state_d = COMMAND;
                        cnt_d   = '0;
                    end else if (cnt_q < CNT_W'(HEADER_WIDTH)) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                COMMAND: begin
                    cmd_sh_d = cmd_word;
                    cnt_d    = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_W'(COMMAND_WIDTH - 1)) begin
                        command_d = cmd_word;
                        cvld_d    = 1'b1;
                        cnt_d     = '0;
                        state_d   = LENGTH;
                    end
                end
                LENGTH: begin
                    len_sh_d = len_word;
                    cnt_d    = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_W'(LENGTH_WIDTH - 1)) begin
                        length_d = len_word;
                        cnt_d    = '0;
                        if (len_word != '0) begin
                            state_d = PAYLOAD;
                        end else begin
                            state_d = AFTER_DATA;
                            done_d  = DONE_AFTER_DATA;
                        end
                    end
                end
                PAYLOAD: begin
                    obit_d = input_bit;
                    ovld_d = 1'b1;
                    cnt_d  = cnt_q + CNT_ONE;
                    if ((cnt_q + CNT_ONE) == CNT_W'(length_q)) begin
                        cnt_d   = '0;
                        state_d = AFTER_DATA;
                        done_d  = DONE_AFTER_DATA;
                    end
                end
`ifdef PKT_CRC_EN
                CRC: begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_W'(7)) begin
                        cnt_d   = '0;
                        state_d = HUNT;
                        done_d  = 1'b1;
                    end
                end
`endif
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HUNT;
            cnt_q     <= '0;
            window_q  <= '0;
            cmd_sh_q  <= '0;
            len_sh_q  <= '0;
            command_q <= '0;
            length_q  <= '0;
            obit_q    <= 1'b0;
            ovld_q    <= 1'b0;
            cvld_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            window_q  <= window_d;
            cmd_sh_q  <= cmd_sh_d;
            len_sh_q  <= len_sh_d;
            command_q <= command_d;
            length_q  <= length_d;
            obit_q    <= obit_d;
            ovld_q    <= ovld_d;
            cvld_q    <= cvld_d;
            done_q    <= done_d;
        end
    end

    assign output_bit        = obit_q;
    assign is_new_output_bit = ovld_q;
    assign command           = command_q;
    assign command_valid     = cvld_q;
    assign payload_length    = length_q;
    assign packet_done       = done_q;
    assign busy              = (state_q != HUNT);

`ifdef PKT_CRC_EN
    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    logic [7:0] crc_q, crc_d, rx_q, rx_d, rx_word;
    logic       crc_err_q, crc_err_d;

    assign rx_word = {input_bit, rx_q[7:1]};

    always_comb begin
        crc_d     = crc_q;
        rx_d      = rx_q;
        crc_err_d = 1'b0;
        if (hdr_match) begin
            crc_d = '0;
        end else if (is_new_input_bit) begin
            if (state_q == COMMAND || state_q == LENGTH || state_q == PAYLOAD) begin
                crc_d = crc8_step(crc_q, input_bit);
            end else if (state_q == CRC) begin
                rx_d = rx_word;
                if (cnt_q == CNT_W'(7)) crc_err_d = (rx_word != crc_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q     <= '0;
            rx_q      <= '0;
            crc_err_q <= 1'b0;
        end else begin
            crc_q     <= crc_d;
            rx_q      <= rx_d;
            crc_err_q <= crc_err_d;
        end
    end

    assign crc_error = crc_err_q;
`else
    assign crc_error = 1'b0;
`endif
endmodule

// File: tb/tb_stream_packet_parser.sv
// Directed bench for stream_packet_parser; define PKT_CRC_EN to also exercise the CRC trailer.
`timescale 1ns/1ps
module tb_stream_packet_parser;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        input_bit;
    logic        is_new_input_bit;
    logic        output_bit;
    logic        is_new_output_bit;
    logic [15:0] command;
    logic        command_valid;
    logic [15:0] payload_length;
    logic        packet_done;
    logic        busy;
    logic        crc_error;

    int n_checks = 0;
    int n_fail   = 0;
    int ovld_cnt = 0;
    int done_cnt = 0;
    int snap;
    bit sparse   = 1'b0;
    logic [31:0] pd;

    localparam logic [31:0] HDR = 32'h0000BACD;

`ifdef PKT_CRC_EN
    logic [7:0] crc_corrupt = 8'h00;
`endif

    always #5 clk = ~clk;

    stream_packet_parser dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .input_bit         (input_bit),
        .is_new_input_bit  (is_new_input_bit),
        .output_bit        (output_bit),
        .is_new_output_bit (is_new_output_bit),
        .command           (command),
        .command_valid     (command_valid),
        .payload_length    (payload_length),
        .packet_done       (packet_done),
        .busy              (busy),
        .crc_error         (crc_error)
    );

    always @(posedge clk) begin
        if (is_new_output_bit) ovld_cnt <= ovld_cnt + 1;
        if (packet_done)       done_cnt <= done_cnt + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        if (sparse) begin
            repeat (3) @(posedge clk);
            #1 check("gap_ovld", 32'(is_new_output_bit), 32'd0);
        end
        @(negedge clk);
        input_bit        = b;
        is_new_input_bit = 1'b1;
        @(posedge clk);
        #1;
        is_new_input_bit = 1'b0;
    endtask

    task automatic send_field(input logic [31:0] value, input int width);
        for (int i = 0; i < width; i++) send_bit(value[i]);
    endtask

`ifdef PKT_CRC_EN
    function automatic logic [7:0] crc8(input logic [7:0] c, input logic b);
        logic [7:0] n;
        n = {c[6:0], 1'b0};
        if (c[7] ^ b) n = n ^ 8'h07;
        return n;
    endfunction

    task automatic end_packet(input logic [15:0] cmd, input logic [15:0] len, input logic [31:0] data);
        logic [7:0]  c;
        logic [31:0] cw;
        c = 8'h00;
        for (int i = 0; i < 16; i++) c = crc8(c, cmd[i]);
        for (int i = 0; i < 16; i++) c = crc8(c, len[i]);
        for (int i = 0; i < int'(len); i++) c = crc8(c, data[i]);
        cw = {24'd0, c ^ crc_corrupt};
        for (int i = 0; i < 7; i++) send_bit(cw[i]);
        check("crc_busy", 32'(busy), 32'd1);
        check("crc_no_done", 32'(packet_done), 32'd0);
        send_bit(cw[7]);
        check("crc_err", 32'(crc_error), 32'(crc_corrupt != 8'h00));
        check("done", 32'(packet_done), 32'd1);
        check("busy_end", 32'(busy), 32'd0);
    endtask
`else
    task automatic end_packet();
        check("crc_err", 32'(crc_error), 32'd0);
        check("done", 32'(packet_done), 32'd1);
        check("busy_end", 32'(busy), 32'd0);
    endtask
`endif

    task automatic body_packet(input logic [15:0] cmd, input logic [15:0] len, input logic [31:0] data);
        for (int i = 0; i < 15; i++) send_bit(cmd[i]);
        check("cmd_vld_early", 32'(command_valid), 32'd0);
        send_bit(cmd[15]);
        check("cmd_vld", 32'(command_valid), 32'd1);
        check("cmd", 32'(command), 32'(cmd));
        send_bit(len[0]);
        check("cmd_vld_pulse", 32'(command_valid), 32'd0);
        check("cmd_hold", 32'(command), 32'(cmd));
        for (int i = 1; i < 16; i++) send_bit(len[i]);
        check("len", 32'(payload_length), 32'(len));
        for (int i = 0; i < int'(len); i++) begin
            send_bit(data[i]);
            check("pay_vld", 32'(is_new_output_bit), 32'd1);
            check("pay_bit", 32'(output_bit), 32'(data[i]));
        end
`ifdef PKT_CRC_EN
        end_packet(cmd, len, data);
`else
        end_packet();
`endif
    endtask

    task automatic run_packet(input logic [15:0] cmd, input logic [15:0] len, input logic [31:0] data);
        send_field(HDR, 16);
        check("hdr_busy", 32'(busy), 32'd1);
        check("hdr_no_ovld", 32'(is_new_output_bit), 32'd0);
        body_packet(cmd, len, data);
    endtask

    initial begin
        rst_n            = 1'b0;
        input_bit        = 1'b0;
        is_new_input_bit = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_obit", 32'(output_bit), 32'd0);
        check("rst_ovld", 32'(is_new_output_bit), 32'd0);
        check("rst_cmd", 32'(command), 32'd0);
        check("rst_cvld", 32'(command_valid), 32'd0);
        check("rst_len", 32'(payload_length), 32'd0);
        check("rst_done", 32'(packet_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_crc", 32'(crc_error), 32'd0);
        rst_n = 1'b1;

        // Basic packet: cmd 0x1234, 8-bit payload 0xA5 -> bits 1,0,1,0,0,1,0,1
        run_packet(16'h1234, 16'd8, 32'h000000A5);
        @(posedge clk); #1;
        check("done_pulse", 32'(packet_done), 32'd0);
        check("ovld_idle", 32'(is_new_output_bit), 32'd0);
        check("len_hold", 32'(payload_length), 32'd8);

        // Junk bits 1,1,0,1,1 then header straddling them
        send_field(32'h0000001B, 5);
        check("junk_busy", 32'(busy), 32'd0);
        send_field(HDR, 15);
        check("hdr_partial", 32'(busy), 32'd0);
        send_bit(1'b1);
        check("hdr_unaligned", 32'(busy), 32'd1);
        body_packet(16'hBEEF, 16'd3, 32'h00000006);

        // Zero-length packet followed immediately by another packet
        repeat (2) @(posedge clk); #1;
        snap = ovld_cnt;
        run_packet(16'h00FF, 16'd0, 32'h0);
        send_field(HDR, 16);
        check("b2b_hdr_busy", 32'(busy), 32'd1);
        check("len0_no_ovld", 32'(ovld_cnt), 32'(snap));
        body_packet(16'h5A5A, 16'd2, 32'h00000001);

        // Sparse valid with reset in the middle of the payload
        repeat (2) @(posedge clk); #1;
        snap   = done_cnt;
        sparse = 1'b1;
        send_field(HDR, 16);
        send_field(32'h00000F0F, 16);
        send_field(32'h00000008, 16);
        pd = 32'h00000005;
        for (int i = 0; i < 3; i++) begin
            send_bit(pd[i]);
            check("sp_vld", 32'(is_new_output_bit), 32'd1);
            check("sp_bit", 32'(output_bit), 32'(pd[i]));
        end
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_ovld", 32'(is_new_output_bit), 32'd0);
        check("mid_rst_obit", 32'(output_bit), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_cmd", 32'(command), 32'd0);
        check("mid_rst_len", 32'(payload_length), 32'd0);
        check("mid_rst_done", 32'(packet_done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_packet(16'hC3C3, 16'd4, 32'h00000009);
        check("rst_no_done", 32'(done_cnt), 32'(snap));
        sparse = 1'b0;

`ifdef PKT_CRC_EN
        crc_corrupt = 8'h00;
        run_packet(16'h1234, 16'd8, 32'h000000A5);
        crc_corrupt = 8'h10;
        run_packet(16'h1234, 16'd8, 32'h000000A5);
        @(posedge clk); #1;
        check("crc_err_pulse", 32'(crc_error), 32'd0);
        crc_corrupt = 8'h00;
`endif

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/stream_packet_parser.md
STREAM_PACKET_PARSER -- requirements
Module: stream_packet_parser

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter HEADER_WIDTH SHALL default to 16 and set the header width in bits.
REQ-003 Parameter HEADER SHALL default to 16'hBACD and set the sync word value.
REQ-004 Parameter COMMAND_WIDTH SHALL default to 16 and set the command field width.
REQ-005 Parameter LENGTH_WIDTH SHALL default to 16 and set the width of the payload bit-count field.
REQ-006 Port clk SHALL be an input, 1 bit wide, and the rising-edge clock.
REQ-007 Port rst_n SHALL be an input, 1 bit wide, and the asynchronous active-low reset.
REQ-008 Port input_bit SHALL be an input, 1 bit wide, and carry the serial data bit.
REQ-009 Port is_new_input_bit SHALL be an input, 1 bit wide, and qualify input_bit for one cycle.
REQ-010 Port output_bit SHALL be an output, 1 bit wide, and carry the payload bit.
REQ-011 Port is_new_output_bit SHALL be an output, 1 bit wide, and qualify output_bit.
REQ-012 Port command SHALL be an output, COMMAND_WIDTH wide, and hold the last decoded command.
REQ-013 Port command_valid SHALL be an output, 1 bit wide, and pulse for 1 cycle when command updates.
REQ-014 Port payload_length SHALL be an output, LENGTH_WIDTH wide, and hold the last decoded length.
REQ-015 Port packet_done SHALL be an output, 1 bit wide, and pulse for 1 cycle at the end of a packet.
REQ-016 Port busy SHALL be an output, 1 bit wide, and be high in any state other than HUNT.
REQ-017 Port crc_error SHALL be an output, 1 bit wide, and pulse for 1 cycle on a CRC mismatch.

Function
REQ-018 All fields SHALL be received LSB-first, and only cycles with is_new_input_bit=1 SHALL advance any state or counter.
REQ-019 The FSM SHALL have the states HUNT, COMMAND, LENGTH, PAYLOAD and CRC (CRC only under PKT_CRC_EN).
REQ-020 In HUNT, the last HEADER_WIDTH bits SHALL be held in a sliding window (new bit enters at the MSB), and a match SHALL require the window to equal HEADER and at least HEADER_WIDTH bits received since entering HUNT; header detection is unaligned.
REQ-021 On a match, the FSM SHALL go to COMMAND, and the bit counter SHALL clear.
REQ-022 After COMMAND_WIDTH bits, the command register and a 1-cycle command_valid pulse SHALL be issued in the same clock edge as the last bit, and the FSM SHALL go to LENGTH.
REQ-023 After LENGTH_WIDTH bits, payload_length SHALL update; if the value is 0, the FSM SHALL skip PAYLOAD (to CRC if enabled, else to HUNT with packet_done).
REQ-024 In PAYLOAD, each accepted bit SHALL appear on output_bit with is_new_output_bit=1 exactly 1 cycle later; is_new_output_bit SHALL be 0 at all other times.
REQ-025 After payload_length payload bits, the FSM SHALL leave PAYLOAD; the last bit SHALL still be forwarded.
REQ-026 On return to HUNT, the window-fill count SHALL clear so that stale bits never form a match.
REQ-027 The counters SHALL be sized max(HEADER_WIDTH, COMMAND_WIDTH, LENGTH_WIDTH, 2^LENGTH_WIDTH-1), and a length of 2^LENGTH_WIDTH-1 SHALL be legal without wrap-around.
REQ-028 Back-to-back packets SHALL be supported with zero idle bits between them.
REQ-029 command and payload_length SHALL hold their value until the next update.

Reset
REQ-030 rst_n=0 SHALL asynchronously force state=HUNT, all counters and the window to 0, command=0, payload_length=0, and output_bit, is_new_output_bit, command_valid, packet_done, busy and crc_error to 0.
REQ-031 Reset mid-packet SHALL abandon the packet with no packet_done, and the next header SHALL be hunted from scratch after release.

Configuration
REQ-032 With PKT_CRC_EN defined, a CRC-8 (poly 0x07, init 0x00, MSB-feedback over bits in arrival order) SHALL cover the command, length and payload bits, followed by 8 received CRC bits in the CRC state.
REQ-033 With PKT_CRC_EN defined, a mismatch SHALL pulse crc_error alongside packet_done.
REQ-034 Without PKT_CRC_EN, there SHALL be no CRC state, the FSM SHALL go from PAYLOAD to HUNT, crc_error SHALL be tied to 0, and no CRC logic SHALL be instantiated.

Verification
REQ-035 Send header 0xBACD, cmd 0x1234, len 8, payload 0xA5 -> command=0x1234 with command_valid once, 8 output bits 1,0,1,0,0,1,0,1 (LSB-first) each 1 cycle after input, then packet_done.
REQ-036 Send 5 junk bits, then a header split across bit positions -> header detected, proving the unaligned sliding match.
REQ-037 Send len=0 -> packet_done with no is_new_output_bit pulse; an immediate second packet SHALL also decode.
REQ-038 Sparse valid (is_new_input_bit 1-in-4) with rst_n pulsed low during PAYLOAD -> outputs clear at once; after release, the next full packet decodes correctly.
REQ-039 Under PKT_CRC_EN, send a correct CRC, then a corrupted CRC byte -> crc_error=0 on the first packet and a 1-cycle crc_error=1 on the second.
